sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Shares the single 128-bit memory controller port between two requesters. The SD-card loader is the write requester, using a req/op_begun handshake. The playback fetch engine is the read requester, using req/op_begun plus a returned-data strobe. Reads have priority because they feed audio output. A starvation limit guarantees the loader makes progress, and a read-return timeout protects against a hung controller.

Parameters:
MAX_RD_STREAK, 4, maximum consecutive read grants while a write is pending before a write is forced.
RD_TIMEOUT, 1024, cycles to wait for mem_rvalid after a read is accepted before aborting.
ADDR_W, 22, word address width.
DATA_W, 128, data word width.

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
wr_req  in  1  loader write request (the loader's ram_we); held until wr_op_begun
wr_addr  in  ADDR_W  loader word address
wr_data  in  DATA_W  loader write data
wr_op_begun  out  1  one-cycle acknowledge to the loader
rd_req  in  1  playback read request; held until rd_op_begun
rd_addr  in  ADDR_W  playback word address
rd_op_begun  out  1  one-cycle acknowledge that the read was accepted
rd_data  out  DATA_W  returned read data, registered
rd_valid  out  1  one-cycle strobe; rd_data is valid in that cycle
mem_req  out  1  request to memory controller
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_ack  in  1  controller has begun the operation (single-cycle pulse)
mem_rvalid  in  1  read data valid (single-cycle pulse)
mem_rdata  in  DATA_W  read data
rd_timeout_err  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; streak counter 0; timeout counter 0.
- State IDLE, arbitration each cycle:
  - If rd_req=1 and (wr_req=0 or streak<MAX_RD_STREAK): latch rd_addr into mem_addr, mem_we<=0, go to RD_ISSUE.
  - Else if wr_req=1: latch wr_addr and wr_data into mem_addr and mem_wdata, mem_we<=1, go to WR_ISSUE.
  - Else stay in IDLE.
  - mem_req is asserted from the cycle after the grant, so grant-to-mem_req latency is 1 cycle.
- State WR_ISSUE:
  - mem_req=1, mem_we=1.
  - On mem_ack: wr_op_begun=1 in that same cycle (combinational), streak<=0, go to IDLE.
  - A new grant can be made no earlier than the cycle after the ack.
- State RD_ISSUE:
  - mem_req=1, mem_we=0.
  - On mem_ack: rd_op_begun=1 in that same cycle, timeout counter<=0, go to RD_WAIT.
  - Streak update on that ack: if wr_req=1, streak<=streak+1, saturating at MAX_RD_STREAK; otherwise streak<=0.
- State RD_WAIT:
  - mem_req=0.
  - On mem_rvalid: rd_data<=mem_rdata and rd_valid=1 in the following cycle (registered, 1-cycle latency), then go to IDLE.
  - Otherwise the counter increments. When it reaches RD_TIMEOUT-1 without mem_rvalid: set rd_timeout_err, pulse no rd_valid, go to IDLE.
  - A mem_rvalid arriving after the timeout is ignored.
- Streak rule: the streak clears whenever a write is granted or wr_req=0 at a read ack. With MAX_RD_STREAK=4 and both requests continuously high, the grant order is R,R,R,R,W,R,R,R,R,W...
- Simultaneous rd_req and wr_req with streak below the limit: the read wins.
- mem_ack outside WR_ISSUE or RD_ISSUE is ignored; no op_begun is generated.
- Requester changes: a requester that drops req before its op_begun is still serviced once the grant is latched, and its op_begun is still pulsed. Address and data are taken from the grant-cycle snapshot.
- Only one outstanding memory operation at a time. No pipelining across RD_WAIT.
- Reset asserted mid-operation: return to IDLE immediately and clear all outputs and rd_timeout_err. Any in-flight controller response is ignored.

Test Plan:
- Single write: wr_req=1, wr_addr=22'h000010, wr_data=128'hA5…A5, mem_ack 3 cycles after mem_req -> mem_we=1; mem_addr/mem_wdata match; one wr_op_begun pulse in the ack cycle; back to IDLE.
- Single read: rd_req=1, rd_addr=22'h3F0000; mem_ack, then mem_rvalid with rdata=128'h1234 after 5 cycles -> one rd_op_begun pulse; rd_valid one cycle after mem_rvalid with rd_data=128'h1234.
- Contention: both requests held high, each op acked after 2 cycles, rvalid after 2 cycles -> grant sequence R,R,R,R,W,R,R,R,R,W over 10 operations.
- Write only: rd_req=0, wr_req held for 8 operations -> 8 consecutive writes; streak stays 0; mem_addr tracks each new wr_addr.
- Timeout: read accepted, mem_rvalid never arrives -> after 1024 cycles rd_timeout_err=1 and no rd_valid; a pending write is granted next; a late mem_rvalid produces no rd_valid.
- Reset mid-read: reset asserted in RD_WAIT for 1 cycle -> all outputs 0, state IDLE, rd_timeout_err=0; the next rd_req is serviced normally.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-requester arbiter for the 128-bit memory controller port
// Reads win unless a pending write has lost MAX_RD_STREAK grants in a row; reads are guarded by a return timeout.
module sdram_port_arbiter #(
    parameter int MAX_RD_STREAK = 4,
    parameter int RD_TIMEOUT    = 1024,
    parameter int ADDR_W        = 22,
    parameter int DATA_W        = 128
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_op_begun,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_op_begun,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_timeout_err
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam int TO_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [STREAK_W-1:0] r_streak;
    logic [TO_W-1:0]     r_to_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_timeout_err;

    logic w_rd_grant;
    logic w_wr_grant;
    logic w_wr_ack;
    logic w_rd_ack;
    logic w_rd_hit;
    logic w_timeout;

    // A write only overrides a read once the read streak has hit its limit.
    assign w_rd_grant = (r_state == IDLE) && rd_req && (!wr_req || (r_streak < STREAK_MAX));
    assign w_wr_grant = (r_state == IDLE) && !w_rd_grant && wr_req;
    assign w_wr_ack   = (r_state == WR_ISSUE) && mem_ack;
    assign w_rd_ack   = (r_state == RD_ISSUE) && mem_ack;
    assign w_rd_hit   = (r_state == RD_WAIT) && mem_rvalid;
    assign w_timeout  = (r_state == RD_WAIT) && !mem_rvalid && (r_to_cnt == TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rd_grant)      w_next = RD_ISSUE;
                else if (w_wr_grant) w_next = WR_ISSUE;
            end
            WR_ISSUE: if (mem_ack) w_next = IDLE;
            RD_ISSUE: if (mem_ack) w_next = RD_WAIT;
            RD_WAIT:  if (w_rd_hit || w_timeout) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state       <= IDLE;
            r_streak      <= '0;
            r_to_cnt      <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= 1'b0;
            if (w_rd_grant) begin
                r_mem_addr <= rd_addr;
                r_mem_we   <= 1'b0;
            end else if (w_wr_grant) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
                r_mem_we    <= 1'b1;
                r_streak    <= '0;
            end
            if (w_wr_ack) begin
                r_streak <= '0;
            end
            if (w_rd_ack) begin
                r_to_cnt <= '0;
                if (!wr_req)                 r_streak <= '0;
                else if (r_streak < STREAK_MAX) r_streak <= r_streak + STREAK_W'(1);
            end
            if (r_state == RD_WAIT) begin
                if (mem_rvalid) begin
                    r_rd_data  <= mem_rdata;
                    r_rd_valid <= 1'b1;
                end else if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

    assign mem_req        = (r_state == WR_ISSUE) || (r_state == RD_ISSUE);
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign wr_op_begun    = w_wr_ack;
    assign rd_op_begun    = w_rd_ack;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign rd_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    logic         clk50 = 1'b0;
    logic         reset;
    logic         wr_req;
    logic [21:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_op_begun;
    logic         rd_req;
    logic [21:0]  rd_addr;
    logic         rd_op_begun;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         mem_req;
    logic         mem_we;
    logic [21:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
    logic         rd_timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    sdram_port_arbiter dut (
        .clk50          (clk50),
        .reset          (reset),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_op_begun    (wr_op_begun),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_op_begun    (rd_op_begun),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rd_timeout_err (rd_timeout_err)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk50);
        end
        check("mem_req_seen", seen, 1);
    endtask

    // Acts as the controller for one operation; optionally drops the serviced request after its ack.
    task automatic serve(input int ack_dly, input int rv_dly, input logic [127:0] rdata, input bit drop,
                         output logic we, output logic [21:0] addr, output logic [127:0] wdata);
        bit seen;
        wait_req(seen);
        we = mem_we;
        addr = mem_addr;
        wdata = mem_wdata;
        if (seen) begin
            repeat (ack_dly) @(negedge clk50);
            check("mem_req_held", mem_req, 1);
            mem_ack = 1'b1;
            #1;
            check("wr_op_begun_ack", wr_op_begun, we);
            check("rd_op_begun_ack", rd_op_begun, !we);
            @(negedge clk50);
            mem_ack = 1'b0;
            #1;
            check("op_begun_single", wr_op_begun | rd_op_begun, 0);
            check("mem_req_after_ack", mem_req, 0);
            if (drop) begin
                if (we) wr_req = 1'b0;
                else    rd_req = 1'b0;
            end
            if (!we) begin
                repeat (rv_dly - 1) @(negedge clk50);
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                #1;
                check("rd_valid_early", rd_valid, 0);
                @(negedge clk50);
                mem_rvalid = 1'b0;
                check("rd_valid_pulse", rd_valid, 1);
                check("rd_data", rd_data, rdata);
                @(negedge clk50);
                check("rd_valid_single", rd_valid, 0);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         we;
        logic [21:0]  addr;
        logic [127:0] wd;
        bit           seen;
        bit           got_rv;
        int           cnt;

        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk50);
        reset = 1'b0;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_err", rd_timeout_err, 0);

        // Stray ack while idle must not produce an acknowledge.
        mem_ack = 1'b1;
        #1;
        check("idle_ack_wr", wr_op_begun, 0);
        check("idle_ack_rd", rd_op_begun, 0);
        @(negedge clk50);
        mem_ack = 1'b0;
        check("idle_ack_noreq", mem_req, 0);

        // Single write
        wr_req = 1'b1; wr_addr = 22'h000010; wr_data = {16{8'hA5}};
        serve(3, 0, '0, 1'b1, we, addr, wd);
        check("sw_we", we, 1);
        check("sw_addr", addr, 22'h000010);
        check("sw_wdata", wd, {16{8'hA5}});
        @(negedge clk50);
        check("sw_idle", mem_req, 0);

        // Single read
        rd_req = 1'b1; rd_addr = 22'h3F0000;
        serve(1, 5, 128'h1234, 1'b1, we, addr, wd);
        check("sr_we", we, 0);
        check("sr_addr", addr, 22'h3F0000);
        @(negedge clk50);
        check("sr_idle", mem_req, 0);

        // Contention: R,R,R,R,W repeating
        rd_req = 1'b1; rd_addr = 22'h000200;
        wr_req = 1'b1; wr_addr = 22'h000300; wr_data = 128'hCAFE;
        for (int i = 0; i < 10; i++) begin
            serve(2, 2, 128'h5000 + 128'(i), 1'b0, we, addr, wd);
            check($sformatf("cont_grant%0d", i), we, (i % 5 == 4));
            check($sformatf("cont_addr%0d", i), addr, (i % 5 == 4) ? 22'h000300 : 22'h000200);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (2) @(negedge clk50);

        // Write only: 8 back-to-back writes
        wr_req = 1'b1; wr_addr = 22'h000100; wr_data = {4{32'd0}};
        for (int i = 0; i < 8; i++) begin
            serve(1, 0, '0, 1'b0, we, addr, wd);
            check($sformatf("wo_we%0d", i), we, 1);
            check($sformatf("wo_addr%0d", i), addr, 22'h000100 + 22'(i));
            check($sformatf("wo_wdata%0d", i), wd, {4{32'(i)}});
            wr_addr = 22'h000100 + 22'(i + 1);
            wr_data = {4{32'(i + 1)}};
        end
        wr_req = 1'b0;
        repeat (2) @(negedge clk50);

        // Timeout, then the pending write, then a late rvalid
        rd_req = 1'b1; rd_addr = 22'h000123;
        wait_req(seen);
        mem_ack = 1'b1;
        #1;
        check("to_rd_op_begun", rd_op_begun, 1);
        @(negedge clk50);
        mem_ack = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b1; wr_addr = 22'h2AAAAA; wr_data = 128'h77;
        cnt = 0; got_rv = 1'b0;
        while (!rd_timeout_err && cnt < 1100) begin
            if (rd_valid) got_rv = 1'b1;
            @(negedge clk50);
            cnt++;
        end
        check("to_cycles", 128'(cnt), 1024);
        check("to_no_rvalid", got_rv, 0);
        mem_rvalid = 1'b1; mem_rdata = 128'hDEAD;
        @(negedge clk50);
        mem_rvalid = 1'b0;
        check("to_late_rvalid", rd_valid, 0);
        serve(1, 0, '0, 1'b1, we, addr, wd);
        check("to_wr_we", we, 1);
        check("to_wr_addr", addr, 22'h2AAAAA);
        check("to_err_sticky", rd_timeout_err, 1);

        // Reset during RD_WAIT
        rd_req = 1'b1; rd_addr = 22'h0ABCDE;
        wait_req(seen);
        mem_ack = 1'b1;
        @(negedge clk50);
        mem_ack = 1'b0;
        rd_req = 1'b0;
        @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        reset = 1'b0;
        check("mr_mem_req", mem_req, 0);
        check("mr_mem_we", mem_we, 0);
        check("mr_mem_addr", mem_addr, 0);
        check("mr_mem_wdata", mem_wdata, 0);
        check("mr_rd_data", rd_data, 0);
        check("mr_rd_valid", rd_valid, 0);
        check("mr_err", rd_timeout_err, 0);
        mem_rvalid = 1'b1; mem_rdata = 128'hBAD;
        @(negedge clk50);
        mem_rvalid = 1'b0;
        @(negedge clk50);
        check("mr_stale_rvalid", rd_valid, 0);
        rd_req = 1'b1; rd_addr = 22'h011111;
        serve(1, 2, 128'hBEEF, 1'b1, we, addr, wd);
        check("mr_rd_we", we, 0);
        check("mr_rd_addr", addr, 22'h011111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
